// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared encodings for the instruction-fetch controller
package if_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] IF_RESET_PC      = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // What the IF/ID latch does on the coming edge.
    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_t;

endpackage

// File: rtl/if_next_pc_sel.sv
// rtl/if_next_pc_sel.sv - next-PC, IF/ID action and next-state decode
module if_next_pc_sel
    import if_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  fetch_state_t     state,
    input  logic             branch_taken,
    input  logic             stall,
    input  logic             halt_req,
    input  logic [WIDTH-1:0] branch_target,
    input  logic [WIDTH-1:0] pc_cur,
    input  logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] pc_next,
    output ifid_op_t         ifid_op,
    output fetch_state_t     state_next
);

    always_comb begin
        pc_next    = pc_cur;
        ifid_op    = IFID_HOLD;
        state_next = state;
        case (state)
            ST_BOOT: begin
                state_next = ST_RUN;
                ifid_op    = IFID_BUBBLE;
            end
            ST_RUN: begin
                // A redirect flushes even a stalled IF/ID.
                if (branch_taken) begin
                    pc_next = branch_target;
                    ifid_op = IFID_BUBBLE;
                end else if (!stall) begin
                    pc_next = pc_inc;
                    ifid_op = IFID_LOAD;
                end
                if (halt_req) begin
                    state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                ifid_op = IFID_BUBBLE;
            end
            default: begin
                state_next = ST_BOOT;
                ifid_op    = IFID_BUBBLE;
            end
        endcase
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch stage: PC register, IF/ID latch, FSM, checks
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IF_RESET_PC),
    parameter int               CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [WIDTH-1:0]   pc_out,
    input  logic [WIDTH-1:0]   pc_inc,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               branch_taken,
    input  logic [WIDTH-1:0]   branch_target,
    input  logic               stall,
    input  logic               halt_req,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [WIDTH-1:0]   ifid_npc,
    output logic               ifid_valid,
    output logic               halted,
    output logic               inc_err,
    output logic [CNT_W-1:0]   fetch_cnt
);

    fetch_state_t     state;
    fetch_state_t     state_next;
    ifid_op_t         ifid_op;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc_plus1;

    assign pc_plus1 = pc_out + WIDTH'(1);

    if_next_pc_sel #(.WIDTH(WIDTH)) u_next_pc_sel (
        .state         (state),
        .branch_taken  (branch_taken),
        .stall         (stall),
        .halt_req      (halt_req),
        .branch_target (branch_target),
        .pc_cur        (pc_out),
        .pc_inc        (pc_inc),
        .pc_next       (pc_next),
        .ifid_op       (ifid_op),
        .state_next    (state_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_BOOT;
            pc_out     <= RESET_PC;
            ifid_instr <= INSTR_W'(NOP);
            ifid_npc   <= '0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
            inc_err    <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            state  <= state_next;
            halted <= (state_next == ST_HALT);
            pc_out <= pc_next;
            case (ifid_op)
                IFID_LOAD: begin
                    ifid_instr <= instr_in;
                    ifid_npc   <= pc_inc;
                    ifid_valid <= 1'b1;
                    if (fetch_cnt != '1) begin
                        fetch_cnt <= fetch_cnt + CNT_W'(1);
                    end
                    // The external incrementer is only trusted on edges that consume it.
                    if (pc_inc != pc_plus1) begin
                        inc_err <= 1'b1;
                    end
                end
                IFID_BUBBLE: begin
                    ifid_instr <= INSTR_W'(NOP);
                    ifid_npc   <= '0;
                    ifid_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
